uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 10416, clocks per UART bit (100 MHz / 9600); legal range 2..65535.
REQ-002 SHALL have parameter NREQ, fixed at 3, number of requesters sharing the transmitter.
REQ-003 SHALL have port sys_clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 3, per-requester byte-available flag.
REQ-006 SHALL have port req_data, input, 24, packed bytes; requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, 3, one-hot accept strobe; byte i is transferred in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 SHALL have port uart_txd, output, 1, serial line, idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress (any state other than IDLE).
REQ-010 SHALL have port grant_id, output, 2, index of the requester whose byte is currently being sent; holds its last value while idle.

Function
REQ-011 SHALL implement the states IDLE, START, DATA and STOP.
REQ-012 In IDLE with any req_valid bit set, req_ready SHALL be high combinationally for exactly one selected index; req_ready SHALL be 0 in every other state.
REQ-013 Selection SHALL be round-robin, searching last+1, last+2, last+3 (mod 3) for the first valid requester, where last is the most recently granted index.
REQ-014 On a transfer, the following cycle SHALL latch the byte and its index into grant_id and last, enter START, and clear the baud counter.
REQ-015 The baud counter SHALL count 0..BAUD_DIV-1, be 16 bits wide, and wrap to 0, giving a bit-end event at count BAUD_DIV-1.
REQ-016 START SHALL drive uart_txd=0 for BAUD_DIV cycles, then enter DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each for BAUD_DIV cycles, using a 3-bit bit index that advances at each bit-end; after bit 7 it SHALL enter STOP.
REQ-018 STOP SHALL drive uart_txd=1 for BAUD_DIV cycles, then return to IDLE.
REQ-019 uart_txd SHALL be driven from a register, with no combinational glitch path.
REQ-020 A frame SHALL last exactly 10*BAUD_DIV cycles from the first START cycle to the first IDLE cycle.
REQ-021 Back-to-back frames SHALL be spaced 10*BAUD_DIV+1 cycles start-to-start, because of the one IDLE accept cycle.
REQ-022 Changes to req_valid or req_data outside IDLE SHALL have no effect on the frame in progress.
REQ-023 Requesters SHALL hold req_valid and data stable until accepted; a requester deasserting before accept SHALL simply not be granted.
REQ-024 If all three requesters are valid continuously, grants SHALL rotate 0,1,2,0,... with no starvation.

Reset
REQ-025 While rst=1, the block SHALL set: state IDLE, uart_txd=1, busy=0, req_ready=0, grant_id=0, last=2 (so requester 0 has first priority), and baud counter and bit index to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame: uart_txd=1 on the cycle after the reset edge, and the aborted byte is discarded with no re-send.
REQ-027 In the first cycle after rst deasserts with req_valid nonzero, the block SHALL accept immediately per REQ-012.

Verification (BAUD_DIV=4 unless noted)
REQ-028 Single byte: req_valid=001 and data0=0xA5 -> req_ready=001 in the same cycle; then uart_txd = 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles; busy high for 40 cycles.
REQ-029 Round-robin: all valid with distinct bytes 0x11/0x22/0x33 held -> grant_id sequence 0,1,2,0 with 41-cycle frame spacing.
REQ-030 Fairness skip: req_valid=101 constant after a grant to 0 -> the next grant is 2, then 0.
REQ-031 Reset mid-DATA: rst pulsed at bit 3 -> uart_txd=1 and busy=0 on the next cycle; the next frame starts with requester 0 priority.
REQ-032 Data change mid-frame: data0 changed during DATA -> the serialized byte is unchanged.
REQ-033 Default BAUD_DIV=10416: one 0x00 byte -> uart_txd low for exactly 93744 cycles, then high.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets three requesters share one 8N1 UART transmitter.
// A byte is accepted only in IDLE; the frame then runs from latched copies.
module uart_tx_sched #(
  parameter int unsigned BAUD_DIV = 10416,
  parameter int unsigned NREQ     = 3
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                uart_txd,
  output logic                busy,
  output logic [1:0]          grant_id
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } TxState_e;

  TxState_e    state_q;
  logic [15:0] baudCnt_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  data_q;
  logic        txd_q;
  logic        busy_q;
  logic [1:0]  grant_q;
  logic [1:0]  last_q;

  logic [1:0]  pickIdx_d;
  logic        pickHit_d;
  logic [7:0]  pickByte_d;
  logic [1:0]  cand;
  logic        bitEnd;

  assign bitEnd   = (baudCnt_q == BAUD_LAST);
  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

  // Search last+1, last+2, last+3 (mod 3); the first valid requester wins.
  always_comb begin
    pickIdx_d = last_q;
    pickHit_d = 1'b0;
    cand      = last_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!pickHit_d && req_valid[cand]) begin
        pickHit_d = 1'b1;
        pickIdx_d = cand;
      end
    end
  end

  always_comb begin
    case (pickIdx_d)
      2'd0:    pickByte_d = req_data[7:0];
      2'd1:    pickByte_d = req_data[15:8];
      2'd2:    pickByte_d = req_data[23:16];
      default: pickByte_d = 8'h00;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && pickHit_d) begin
      req_ready[pickIdx_d] = 1'b1;
    end
  end

  // Frame sequencer; txd is registered so the line never sees decode glitches.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baudCnt_q <= 16'd0;
      bitIdx_q  <= 3'd0;
      data_q    <= 8'h00;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      grant_q   <= 2'd0;
      last_q    <= 2'd2;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickHit_d) begin
            state_q   <= START;
            data_q    <= pickByte_d;
            grant_q   <= pickIdx_d;
            last_q    <= pickIdx_d;
            baudCnt_q <= 16'd0;
            bitIdx_q  <= 3'd0;
            txd_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            state_q   <= DATA;
            baudCnt_q <= 16'd0;
            bitIdx_q  <= 3'd0;
            txd_q     <= data_q[0];
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt_q <= 16'd0;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              txd_q    <= data_q[bitIdx_q + 3'd1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            state_q   <= IDLE;
            baudCnt_q <= 16'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            baudCnt_q <= baudCnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, corner-case sequences
// and a randomized run against a frame-position reference model.
module tb_uart_tx_sched;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reqValid;
  logic [23:0] reqData;
  logic [2:0]  reqReady;
  logic        uartTxd;
  logic        busy;
  logic [1:0]  grantId;

  logic        rst2;
  logic [2:0]  reqValid2;
  logic [23:0] reqData2;
  logic [2:0]  reqReady2;
  logic        uartTxd2;
  logic        busy2;
  logic [1:0]  grantId2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.BAUD_DIV(DIV)) dut (
    .sys_clk  (clk),
    .rst      (rst),
    .req_valid(reqValid),
    .req_data (reqData),
    .req_ready(reqReady),
    .uart_txd (uartTxd),
    .busy     (busy),
    .grant_id (grantId)
  );

  // Minimum legal divider exercises the bit-end boundary at count 1.
  uart_tx_sched #(.BAUD_DIV(2)) dut2 (
    .sys_clk  (clk),
    .rst      (rst2),
    .req_valid(reqValid2),
    .req_data (reqData2),
    .req_ready(reqReady2),
    .uart_txd (uartTxd2),
    .busy     (busy2),
    .grant_id (grantId2)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    logic [2:0]  expReady;
    logic [1:0]  expGrant;
    logic [7:0]  expByte;
    bit          scramble;
  } Vec_t;

  Vec_t vecs[9];

  // Reference model state: a frame is just a position counter 0..FRAME-1.
  bit         mBusy;
  int         mPos;
  logic [7:0] mByte;
  logic [1:0] mGrant;
  logic [1:0] mLast;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int rrPick(input logic [2:0] v, input logic [1:0] last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (int'(last) + k) % 3;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst      = 1'b1;
    reqValid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idleTimeout", {31'd0, busy}, 32'd0);
  endtask

  // Sends one table entry and checks every cycle of the resulting frame.
  task automatic applyStimulus(input Vec_t v);
    logic [9:0] expWave;
    logic [7:0] rxByte;
    logic       expBit;
    int         waveErr;
    int         c;
    expWave = {1'b1, v.expByte, 1'b0};
    rxByte  = 8'h00;
    waveErr = 0;
    @(negedge clk);
    reqValid = v.valid;
    reqData  = v.data;
    #1;
    checkOutput("ready", {29'd0, reqReady}, {29'd0, v.expReady});
    @(posedge clk);
    #1;
    reqValid = 3'b000;
    checkOutput("grant", {30'd0, grantId}, {30'd0, v.expGrant});
    c = 0;
    while (busy && c < FRAME + 10) begin
      expBit = (c / DIV < 10) ? expWave[c / DIV] : 1'b1;
      if (uartTxd !== expBit) waveErr++;
      if (reqReady !== 3'b000) waveErr++;
      if ((c % DIV) == DIV / 2 && c / DIV >= 1 && c / DIV <= 8) rxByte[c / DIV - 1] = uartTxd;
      if (v.scramble && c == 12) begin
        reqData  = ~v.data;
        reqValid = 3'b111;
      end
      if (v.scramble && c == 30) reqValid = 3'b000;
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("frameLen", c, FRAME);
    checkOutput("wave", waveErr, 0);
    checkOutput("byte", {24'd0, rxByte}, {24'd0, v.expByte});
    checkOutput("idleTxd", {31'd0, uartTxd}, 32'd1);
  endtask

  initial begin
    int starts[4];
    int startGrant[4];
    int nStarts;
    int cyc;
    int cnt;
    int lowCnt;
    bit prevBusy;

    rst       = 1'b1;
    reqValid  = 3'b000;
    reqData   = 24'h0;
    rst2      = 1'b1;
    reqValid2 = 3'b000;
    reqData2  = 24'h0;

    vecs[0] = '{3'b001, 24'h0000A5, 3'b001, 2'd0, 8'hA5, 1'b1};
    vecs[1] = '{3'b101, 24'hC3005A, 3'b100, 2'd2, 8'hC3, 1'b0};
    vecs[2] = '{3'b101, 24'hC3005A, 3'b001, 2'd0, 8'h5A, 1'b0};
    vecs[3] = '{3'b111, 24'h332211, 3'b010, 2'd1, 8'h22, 1'b1};
    vecs[4] = '{3'b111, 24'h332211, 3'b100, 2'd2, 8'h33, 1'b0};
    vecs[5] = '{3'b111, 24'h332211, 3'b001, 2'd0, 8'h11, 1'b0};
    vecs[6] = '{3'b010, 24'h000000, 3'b010, 2'd1, 8'h00, 1'b0};
    vecs[7] = '{3'b001, 24'h0000FF, 3'b001, 2'd0, 8'hFF, 1'b0};
    vecs[8] = '{3'b100, 24'h800000, 3'b100, 2'd2, 8'h80, 1'b0};

    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst2 = 1'b0;
    #1;
    checkOutput("rstTxd", {31'd0, uartTxd}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstReady", {29'd0, reqReady}, 32'd0);
    checkOutput("rstGrant", {30'd0, grantId}, 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // All three valid and held: grants rotate with 41-cycle start spacing.
    applyReset();
    reqValid = 3'b111;
    reqData  = 24'h332211;
    nStarts  = 0;
    prevBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      starts[i]     = -1000;
      startGrant[i] = -1;
    end
    for (cyc = 0; cyc < 250 && nStarts < 4; cyc++) begin
      @(negedge clk);
      if (busy && !prevBusy) begin
        starts[nStarts]     = cyc;
        startGrant[nStarts] = int'(grantId);
        nStarts++;
      end
      prevBusy = busy;
    end
    reqValid = 3'b000;
    checkOutput("rrGrant0", startGrant[0], 0);
    checkOutput("rrGrant1", startGrant[1], 1);
    checkOutput("rrGrant2", startGrant[2], 2);
    checkOutput("rrGrant3", startGrant[3], 0);
    checkOutput("rrSpace1", starts[1] - starts[0], FRAME + 1);
    checkOutput("rrSpace2", starts[2] - starts[1], FRAME + 1);
    checkOutput("rrSpace3", starts[3] - starts[2], FRAME + 1);
    #1;
    waitIdle();

    // Reset during DATA bit 3 aborts the frame and restores requester-0 priority.
    applyReset();
    reqValid = 3'b001;
    reqData  = 24'h0000A5;
    @(negedge clk);
    reqValid = 3'b000;
    repeat (17) @(negedge clk);
    #1;
    checkOutput("preRstTxd", {31'd0, uartTxd}, 32'd0);
    checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
    rst      = 1'b1;
    reqValid = 3'b011;
    reqData  = 24'h007766;
    #1;
    checkOutput("readyInRst", {29'd0, reqReady}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abortTxd", {31'd0, uartTxd}, 32'd1);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("readyAfterRst", {29'd0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 3'b000;
    checkOutput("grantAfterRst", {30'd0, grantId}, 32'd0);
    waitIdle();
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    checkOutput("noResend", cnt, 0);

    // BAUD_DIV=2: a 0x00 byte holds the line low for start + 8 data bits.
    @(negedge clk);
    reqValid2 = 3'b001;
    reqData2  = 24'h000000;
    #1;
    checkOutput("div2Ready", {29'd0, reqReady2}, 32'd1);
    @(posedge clk);
    #1;
    reqValid2 = 3'b000;
    lowCnt = 0;
    cnt    = 0;
    while (busy2 && cnt < 100) begin
      if (!uartTxd2) lowCnt++;
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("div2Low", lowCnt, 18);
    checkOutput("div2Len", cnt, 20);
    checkOutput("div2Grant", {30'd0, grantId2}, 32'd0);

    // Randomized run against the reference model.
    applyReset();
    mBusy  = 1'b0;
    mPos   = 0;
    mByte  = 8'h00;
    mGrant = 2'd0;
    mLast  = 2'd2;
    for (int n = 0; n < 3000; n++) begin
      int         pick;
      logic [2:0] expReady;
      logic [9:0] w;
      logic       expTxd;
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) begin
        reqValid = 3'($urandom_range(0, 7));
        reqData  = 24'($urandom);
      end
      #1;
      pick     = rrPick(reqValid, mLast);
      expReady = (!mBusy && !rst && pick >= 0) ? 3'(1 << pick) : 3'b000;
      w        = {1'b1, mByte, 1'b0};
      expTxd   = mBusy ? w[mPos / DIV] : 1'b1;
      checkOutput("rndReady", {29'd0, reqReady}, {29'd0, expReady});
      checkOutput("rndTxd", {31'd0, uartTxd}, {31'd0, expTxd});
      checkOutput("rndBusy", {31'd0, busy}, {31'd0, mBusy});
      checkOutput("rndGrant", {30'd0, grantId}, {30'd0, mGrant});
      @(posedge clk);
      if (rst) begin
        mBusy  = 1'b0;
        mPos   = 0;
        mGrant = 2'd0;
        mLast  = 2'd2;
      end else if (!mBusy) begin
        if (pick >= 0) begin
          mByte  = reqData[8*pick +: 8];
          mGrant = 2'(pick);
          mLast  = 2'(pick);
          mBusy  = 1'b1;
          mPos   = 0;
        end
      end else begin
        mPos++;
        if (mPos == FRAME) mBusy = 1'b0;
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
